// File: rtl/ex_stage_reg.sv
// ex_stage_reg: execute stage and EX/MEM pipeline register with C/Z flags and conditional execution.
// Define EX_FWD_EN to enable MEM/WB operand forwarding; otherwise operands come straight from the register file.
module ex_stage_reg #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        WB_in,
    input  logic [1:0]        Mem_in,
    input  logic [3:0]        Ex_in,
    input  logic [1:0]        cond_in,
    input  logic [DATA_W-1:0] data_read1_in,
    input  logic [DATA_W-1:0] data_read2_in,
    input  logic [DATA_W-1:0] PC_plus_1_in,
    input  logic [DATA_W-1:0] Zero_pad_in,
    input  logic [DATA_W-1:0] sign_ext6_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [REG_AW-1:0] Dest_in,
    input  logic              valid_in,
    input  logic              fwd_mem_en,
    input  logic              fwd_wb_en,
    input  logic [REG_AW-1:0] fwd_mem_dest,
    input  logic [REG_AW-1:0] fwd_wb_dest,
    input  logic [DATA_W-1:0] fwd_mem_data,
    input  logic [DATA_W-1:0] fwd_wb_data,
    input  logic              stall_in,
    input  logic              flush_in,
    output logic [2:0]        WB_out,
    output logic [1:0]        Mem_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic [DATA_W-1:0] PC_plus_1_out,
    output logic [DATA_W-1:0] Zero_pad_out,
    output logic [REG_AW-1:0] Dest_out,
    output logic              valid_out,
    output logic              carry_flag,
    output logic              zero_flag
);
    logic [DATA_W-1:0] op1, op2, b, res;
    logic [DATA_W:0]   sum, diff;
    logic              carry, cp, commit;
`ifdef EX_FWD_EN
    // MEM is the younger producer, so it wins when both stages match
    assign op1 = !src1_in[3] ? data_read1_in :
                 (fwd_mem_en && fwd_mem_dest == src1_in[REG_AW-1:0]) ? fwd_mem_data :
                 (fwd_wb_en && fwd_wb_dest == src1_in[REG_AW-1:0]) ? fwd_wb_data : data_read1_in;
    assign op2 = !src2_in[3] ? data_read2_in :
                 (fwd_mem_en && fwd_mem_dest == src2_in[REG_AW-1:0]) ? fwd_mem_data :
                 (fwd_wb_en && fwd_wb_dest == src2_in[REG_AW-1:0]) ? fwd_wb_data : data_read2_in;
`else
    logic unused_fwd;
    assign op1 = data_read1_in;
    assign op2 = data_read2_in;
    assign unused_fwd = ^{fwd_mem_en, fwd_wb_en, fwd_mem_dest, fwd_wb_dest,
                          fwd_mem_data, fwd_wb_data, src1_in, src2_in};
`endif
    assign b      = Ex_in[2] ? sign_ext6_in : op2;
    assign sum    = {1'b0, op1} + {1'b0, b};
    assign diff   = {1'b0, op1} + {1'b0, ~b} + (DATA_W+1)'(1);
    assign res    = Ex_in[1:0] == 2'b00 ? sum[DATA_W-1:0] :
                    Ex_in[1:0] == 2'b01 ? ~(op1 & b) :
                    Ex_in[1:0] == 2'b10 ? diff[DATA_W-1:0] : b;
    assign carry  = Ex_in[1] ? diff[DATA_W] : sum[DATA_W];
    assign cp     = cond_in == 2'b01 ? carry_flag : cond_in == 2'b10 ? zero_flag : 1'b1;
    assign commit = valid_in & cp & ~stall_in & ~flush_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            WB_out         <= '0;
            Mem_out        <= '0;
            alu_result_out <= '0;
            store_data_out <= '0;
            PC_plus_1_out  <= '0;
            Zero_pad_out   <= '0;
            Dest_out       <= '0;
            valid_out      <= 1'b0;
            carry_flag     <= 1'b0;
            zero_flag      <= 1'b0;
        end else if (flush_in) begin
            WB_out         <= '0;
            Mem_out        <= '0;
            alu_result_out <= '0;
            store_data_out <= '0;
            PC_plus_1_out  <= '0;
            Zero_pad_out   <= '0;
            Dest_out       <= '0;
            valid_out      <= 1'b0;
        end else if (!stall_in) begin
            // a failed condition still flows down as a valid no-op
            WB_out         <= {WB_in[2] & valid_in & cp, WB_in[1:0]};
            Mem_out        <= (valid_in & cp) ? Mem_in : 2'b00;
            alu_result_out <= res;
            store_data_out <= op2;
            PC_plus_1_out  <= PC_plus_1_in;
            Zero_pad_out   <= Zero_pad_in;
            Dest_out       <= Dest_in;
            valid_out      <= valid_in;
            if (commit && Ex_in[3]) begin
                zero_flag <= res == '0;
                if (!Ex_in[0])
                    carry_flag <= carry;
            end
        end
    end
endmodule

// File: tb/tb_ex_stage_reg.sv
// tb_ex_stage_reg: directed self-checking bench for ex_stage_reg; expectations follow EX_FWD_EN.
module tb_ex_stage_reg;
    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  WB_in;
    logic [1:0]  Mem_in;
    logic [3:0]  Ex_in;
    logic [1:0]  cond_in;
    logic [15:0] data_read1_in, data_read2_in, PC_plus_1_in, Zero_pad_in, sign_ext6_in;
    logic [3:0]  src1_in, src2_in;
    logic [2:0]  Dest_in;
    logic        valid_in, fwd_mem_en, fwd_wb_en;
    logic [2:0]  fwd_mem_dest, fwd_wb_dest;
    logic [15:0] fwd_mem_data, fwd_wb_data;
    logic        stall_in, flush_in;
    logic [2:0]  WB_out;
    logic [1:0]  Mem_out;
    logic [15:0] alu_result_out, store_data_out, PC_plus_1_out, Zero_pad_out;
    logic [2:0]  Dest_out;
    logic        valid_out, carry_flag, zero_flag;
    int          passed = 0;
    int          total = 0;

    ex_stage_reg dut (
        .clock(clock), .reset(reset), .WB_in(WB_in), .Mem_in(Mem_in), .Ex_in(Ex_in),
        .cond_in(cond_in), .data_read1_in(data_read1_in), .data_read2_in(data_read2_in),
        .PC_plus_1_in(PC_plus_1_in), .Zero_pad_in(Zero_pad_in), .sign_ext6_in(sign_ext6_in),
        .src1_in(src1_in), .src2_in(src2_in), .Dest_in(Dest_in), .valid_in(valid_in),
        .fwd_mem_en(fwd_mem_en), .fwd_wb_en(fwd_wb_en), .fwd_mem_dest(fwd_mem_dest),
        .fwd_wb_dest(fwd_wb_dest), .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .stall_in(stall_in), .flush_in(flush_in), .WB_out(WB_out), .Mem_out(Mem_out),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .PC_plus_1_out(PC_plus_1_out), .Zero_pad_out(Zero_pad_out), .Dest_out(Dest_out),
        .valid_out(valid_out), .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        reset = 0; WB_in = 0; Mem_in = 0; Ex_in = 0; cond_in = 0;
        data_read1_in = 0; data_read2_in = 0; PC_plus_1_in = 0; Zero_pad_in = 0; sign_ext6_in = 0;
        src1_in = 0; src2_in = 0; Dest_in = 0; valid_in = 0;
        fwd_mem_en = 0; fwd_wb_en = 0; fwd_mem_dest = 0; fwd_wb_dest = 0;
        fwd_mem_data = 0; fwd_wb_data = 0; stall_in = 0; flush_in = 0;
    endtask

    task automatic op(input logic [3:0] ex, input logic [1:0] cond, input logic [15:0] a, input logic [15:0] bb);
        Ex_in = ex; cond_in = cond; data_read1_in = a; data_read2_in = bb; valid_in = 1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1; WB_in = 3'b111; Mem_in = 2'b11; op(4'b1000, 2'b00, 16'hFFFF, 16'h0001);
        PC_plus_1_in = 16'h0042; Zero_pad_in = 16'h00AB; Dest_in = 3'd5;
        tick(); tick();
        total++; if (alu_result_out !== 16'h0) $display("FAIL reset_alu: got %h want 0000", alu_result_out); else passed++;
        total++; if ({WB_out, Mem_out, valid_out} !== 6'b0) $display("FAIL reset_ctrl: got %b want 000000", {WB_out, Mem_out, valid_out}); else passed++;
        total++; if ({carry_flag, zero_flag} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {carry_flag, zero_flag}); else passed++;
        total++; if ({PC_plus_1_out, Zero_pad_out, store_data_out, Dest_out} !== 51'b0) $display("FAIL reset_data: got %h want 0", {PC_plus_1_out, Zero_pad_out, store_data_out, Dest_out}); else passed++;
        reset = 0;
    endtask

    task automatic test_add();
        idle();
        op(4'b1000, 2'b00, 16'hFFFF, 16'h0001);
        WB_in = 3'b101; Mem_in = 2'b10; src1_in = 4'b0001; src2_in = 4'b0010;
        PC_plus_1_in = 16'h0010; Zero_pad_in = 16'h00C3; Dest_in = 3'd6;
        tick();
        total++; if (alu_result_out !== 16'h0000) $display("FAIL add_result: got %h want 0000", alu_result_out); else passed++;
        total++; if ({carry_flag, zero_flag} !== 2'b11) $display("FAIL add_flags: got %b want 11", {carry_flag, zero_flag}); else passed++;
        total++; if ({WB_out, Mem_out, valid_out} !== 6'b101_10_1) $display("FAIL add_ctrl: got %b want 101101", {WB_out, Mem_out, valid_out}); else passed++;
        total++; if ({store_data_out, PC_plus_1_out, Zero_pad_out, Dest_out} !== {16'h0001, 16'h0010, 16'h00C3, 3'd6}) $display("FAIL add_pass: got %h want 0001/0010/00c3/6", {store_data_out, PC_plus_1_out, Zero_pad_out, Dest_out}); else passed++;
    endtask

    task automatic test_forward();
        logic [15:0] exp_mem, exp_wb;
`ifdef EX_FWD_EN
        exp_mem = 16'h1234; exp_wb = 16'hAAAA;
`else
        exp_mem = 16'h0055; exp_wb = 16'h0055;
`endif
        idle();
        op(4'b0000, 2'b00, 16'h0055, 16'h0000);
        src1_in = 4'b1011; src2_in = 4'b0011;
        fwd_mem_en = 1; fwd_mem_dest = 3'd3; fwd_mem_data = 16'h1234;
        fwd_wb_en = 1; fwd_wb_dest = 3'd3; fwd_wb_data = 16'hAAAA;
        tick();
        total++; if (alu_result_out !== exp_mem) $display("FAIL fwd_mem: got %h want %h", alu_result_out, exp_mem); else passed++;
        total++; if (store_data_out !== 16'h0000) $display("FAIL fwd_src2_noreg: got %h want 0000", store_data_out); else passed++;
        fwd_mem_dest = 3'd5;
        tick();
        total++; if (alu_result_out !== exp_wb) $display("FAIL fwd_wb: got %h want %h", alu_result_out, exp_wb); else passed++;
        total++; if ({carry_flag, zero_flag} !== 2'b11) $display("FAIL fwd_flags_held: got %b want 11", {carry_flag, zero_flag}); else passed++;
    endtask

    task automatic test_cond();
        idle();
        op(4'b1000, 2'b00, 16'h0001, 16'h0001);
        tick();
        total++; if ({alu_result_out, carry_flag, zero_flag} !== {16'h0002, 2'b00}) $display("FAIL cond_setup: got %h want 0002/00", {alu_result_out, carry_flag, zero_flag}); else passed++;
        op(4'b1000, 2'b10, 16'h0000, 16'h0000); WB_in = 3'b100; Mem_in = 2'b01;
        tick();
        total++; if ({valid_out, WB_out, Mem_out} !== 6'b1_000_00) $display("FAIL cond_fail_ctrl: got %b want 100000", {valid_out, WB_out, Mem_out}); else passed++;
        total++; if ({carry_flag, zero_flag} !== 2'b00) $display("FAIL cond_fail_flags: got %b want 00", {carry_flag, zero_flag}); else passed++;
        cond_in = 2'b00;
        tick();
        total++; if ({carry_flag, zero_flag} !== 2'b01) $display("FAIL cond_setz: got %b want 01", {carry_flag, zero_flag}); else passed++;
        cond_in = 2'b10;
        tick();
        total++; if ({valid_out, WB_out, Mem_out} !== 6'b1_100_01) $display("FAIL cond_pass_ctrl: got %b want 110001", {valid_out, WB_out, Mem_out}); else passed++;
        cond_in = 2'b01;
        tick();
        total++; if ({WB_out, Mem_out} !== 5'b000_00) $display("FAIL cond_c0_ctrl: got %b want 00000", {WB_out, Mem_out}); else passed++;
    endtask

    task automatic test_stall();
        idle();
        op(4'b1010, 2'b00, 16'h0005, 16'h0003); PC_plus_1_in = 16'h0100;
        tick();
        total++; if ({alu_result_out, carry_flag, zero_flag} !== {16'h0002, 2'b10}) $display("FAIL sub_result: got %h want 0002/10", {alu_result_out, carry_flag, zero_flag}); else passed++;
        stall_in = 1;
        for (int i = 1; i <= 3; i++) begin
            op(4'b1010, 2'b00, 16'(i * 7), 16'(i * 7)); PC_plus_1_in = 16'(i); WB_in = 3'b100;
            tick();
            total++; if ({alu_result_out, PC_plus_1_out, WB_out, carry_flag, zero_flag} !== {16'h0002, 16'h0100, 3'b000, 2'b10}) $display("FAIL stall_hold%0d: got %h want 0002/0100/0/10", i, {alu_result_out, PC_plus_1_out, WB_out, carry_flag, zero_flag}); else passed++;
        end
        stall_in = 0; WB_in = 0;
        op(4'b1001, 2'b00, 16'hFFFF, 16'hFFFF); PC_plus_1_in = 16'h0200;
        tick();
        total++; if ({alu_result_out, PC_plus_1_out, carry_flag, zero_flag} !== {16'h0000, 16'h0200, 2'b11}) $display("FAIL stall_release_nand: got %h want 0000/0200/11", {alu_result_out, PC_plus_1_out, carry_flag, zero_flag}); else passed++;
    endtask

    task automatic test_flush();
        idle();
        op(4'b1000, 2'b00, 16'h0001, 16'h0001); WB_in = 3'b100; Mem_in = 2'b10;
        stall_in = 1; flush_in = 1;
        tick();
        total++; if ({valid_out, WB_out, Mem_out} !== 6'b0) $display("FAIL flush_ctrl: got %b want 000000", {valid_out, WB_out, Mem_out}); else passed++;
        total++; if ({carry_flag, zero_flag} !== 2'b11) $display("FAIL flush_flags: got %b want 11", {carry_flag, zero_flag}); else passed++;
    endtask

    task automatic test_passb_invalid();
        idle();
        op(4'b1111, 2'b00, 16'h1111, 16'h2222); sign_ext6_in = 16'hFFF0;
        tick();
        total++; if ({alu_result_out, carry_flag, zero_flag} !== {16'hFFF0, 2'b10}) $display("FAIL passb: got %h want fff0/10", {alu_result_out, carry_flag, zero_flag}); else passed++;
        op(4'b1000, 2'b00, 16'hFFFF, 16'h0001); valid_in = 0; WB_in = 3'b111; Mem_in = 2'b11;
        tick();
        total++; if ({valid_out, WB_out, Mem_out, carry_flag, zero_flag} !== 8'b0_011_00_10) $display("FAIL invalid: got %b want 00110010", {valid_out, WB_out, Mem_out, carry_flag, zero_flag}); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        idle();
        op(4'b1011, 2'b00, 16'h0000, 16'h7777); WB_in = 3'b100;
        tick();
        stall_in = 1; reset = 1;
        tick();
        total++; if ({alu_result_out, valid_out, WB_out, carry_flag, zero_flag} !== 22'b0) $display("FAIL reset_stall: got %h want 0", {alu_result_out, valid_out, WB_out, carry_flag, zero_flag}); else passed++;
        reset = 0; stall_in = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_forward();
        test_cond();
        test_stall();
        test_flush();
        test_passb_invalid();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
